// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 compression engine.
package sha256_pkg;
   localparam int WORD_W = 32;
   localparam int ROUNDS = 64;

   typedef logic [WORD_W-1:0] word_t;
   // [7] = a .. [0] = h, so a 256-bit chaining value maps straight across
   typedef logic [7:0][WORD_W-1:0] vars_t;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   localparam word_t K [0:ROUNDS-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam vars_t H_INIT = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction
endpackage

// File: rtl/sha256_compress_if.sv
// Block-level bus between the multi-block controller / schedule expander and the engine.
interface sha256_compress_if;
   import sha256_pkg::*;

   logic       start;
   vars_t      hash_in;
   word_t      w_in;
   logic       w_valid;
   logic       w_ready;
   logic [5:0] round_idx;
   logic       busy;
   logic       done;
   vars_t      digest_out;

   modport master (
      output start, hash_in, w_in, w_valid,
      input  w_ready, round_idx, busy, done, digest_out
   );

   modport slave (
      input  start, hash_in, w_in, w_valid,
      output w_ready, round_idx, busy, done, digest_out
   );
endinterface

// File: rtl/sha256_round_logic.sv
// One combinational SHA-256 round: working variables in, updated working variables out.
module sha256_round_logic
   import sha256_pkg::*;
(
   input  vars_t v_in,
   input  word_t k_t,
   input  word_t w_t,
   output vars_t v_out
);
   word_t a, b, c, d, e, f, g, h;
   word_t sum0, sum1, ch, maj, t1, t2;

   assign {a, b, c, d, e, f, g, h} = v_in;

   assign sum1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
   assign sum0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
   assign ch   = (e & f) ^ (~e & g);
   assign maj  = (a & b) ^ (a & c) ^ (b & c);
   assign t1   = h + sum1 + ch + k_t + w_t;
   assign t2   = sum0 + maj;

   assign v_out = {word_t'(t1 + t2), a, b, c, word_t'(d + t1), e, f, g};
endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 rounds per block, one W_t per accepted handshake.
//
// state | meaning
// IDLE  | waiting for start; digest_out holds the last result
// ROUND | one round per accepted W_t, round_idx = t being consumed
// FINAL | done pulse; digest_out carries H + final working vars
module sha256_compress
   import sha256_pkg::*;
(
   input logic              clock,
   input logic              reset,
   sha256_compress_if.slave bus
);
   state_t     state_q, state_d;
   logic [5:0] t_q;
   vars_t      vars_q, h_q, digest_q, vars_next, final_sum;
   logic       done_q;
   logic       take, last;

   assign take = (state_q == ROUND) && bus.w_valid;
   assign last = take && (t_q == 6'(ROUNDS - 1));

   sha256_round_logic u_round (
      .v_in  (vars_q),
      .k_t   (K[t_q]),
      .w_t   (bus.w_in),
      .v_out (vars_next)
   );

   // Digest is formed on the last transfer so it appears together with done.
   always_comb begin
      final_sum = '0;
      for (int i = 0; i < 8; i++) begin
         final_sum[i] = h_q[i] + vars_next[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      bus.w_ready = 1'b0;
      bus.busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = ROUND;
         end
         ROUND: begin
            bus.w_ready = 1'b1;
            bus.busy    = 1'b1;
            if (last) state_d = FINAL;
         end
         FINAL: begin
            bus.busy = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         t_q      <= '0;
         vars_q   <= '0;
         h_q      <= '0;
         digest_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last;
         if (state_q == IDLE && bus.start) begin
            vars_q <= bus.hash_in;
            h_q    <= bus.hash_in;
            t_q    <= '0;
         end else if (take) begin
            vars_q <= vars_next;
            t_q    <= t_q + 1'b1;
         end
         if (last) digest_q <= final_sum;
      end
   end

   assign bus.round_idx  = t_q;
   assign bus.done       = done_q;
   assign bus.digest_out = digest_q;
endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: known digests, stalls, start-while-busy, reset mid-block, two blocks.
module tb_sha256_compress;
   import sha256_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   sha256_compress_if bus();
   sha256_compress dut (.clock(clock), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;
   logic [31:0] sched [64];

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] B1_BLK = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B2_BLK = {480'h0, 32'h000001c0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   typedef struct packed {
      logic [255:0] hin;
      logic [511:0] blk;
      logic [255:0] exp;
      logic         stall;
      logic         poke;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic expand(input logic [511:0] blk);
      logic [31:0] s0, s1;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) sched[t] = blk[511 - 32*t -: 32];
         else begin
            s0 = ror32(sched[t-15], 7) ^ ror32(sched[t-15], 18) ^ (sched[t-15] >> 3);
            s1 = ror32(sched[t-2], 17) ^ ror32(sched[t-2], 19) ^ (sched[t-2] >> 10);
            sched[t] = sched[t-16] + s0 + sched[t-7] + s1;
         end
      end
   endtask

   // Reference compression over the current schedule
   function automatic logic [255:0] model_compress(input logic [255:0] hin);
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror32(v[4], 6) ^ ror32(v[4], 11) ^ ror32(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + sched[t];
         t2 = (ror32(v[0], 2) ^ ror32(v[0], 13) ^ ror32(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   // Drives one block; cycle 0 is the cycle start is sampled in.
   task automatic run_block(input logic [255:0] hin, input logic [511:0] blk, input logic stall,
                            input logic poke, input int abort_at,
                            output logic [255:0] dig, output int done_cyc, output int nstall);
      int t;
      bit got;
      expand(blk);
      t = 0; got = 0; nstall = 0; done_cyc = -1; dig = '0;
      @(negedge clock);
      bus.hash_in = hin;
      bus.start   = 1'b1;
      bus.w_valid = 1'b0;
      for (int cyc = 1; cyc < 300 && !got; cyc++) begin
         @(negedge clock);
         bus.start = poke && (cyc == 10);
         if (poke && cyc == 10) bus.hash_in = '1;
         if (abort_at >= 0 && t == abort_at) begin
            bus.w_valid = 1'b0;
            reset = 1'b0;
            return;
         end
         if (bus.done) begin
            got = 1; done_cyc = cyc; dig = bus.digest_out;
            chk("busy_in_final", bus.busy, 1);
            chk("words_accepted", t, 64);
            bus.w_valid = 1'b0;
            if (poke) bus.start = 1'b1;
         end else begin
            chk("w_ready_in_round", bus.w_ready, 1);
            chk("round_idx", bus.round_idx, t);
            if ((stall && cyc % 3 == 0) || t > 63) begin
               bus.w_valid = 1'b0;
               nstall++;
            end else begin
               bus.w_valid = 1'b1;
               bus.w_in    = sched[t];
               t++;
            end
         end
      end
      if (!got) chk("done_timeout", 0, 1);
   endtask

   logic [255:0] dig, mid;
   int dc, ns, seen;

   initial begin
      bus.start = 1'b0; bus.hash_in = '0; bus.w_in = '0; bus.w_valid = 1'b0;
      vecs[0] = '{hin: H_INIT, blk: ABC_BLK,   exp: ABC_DIG,   stall: 1'b0, poke: 1'b0};
      vecs[1] = '{hin: H_INIT, blk: EMPTY_BLK, exp: EMPTY_DIG, stall: 1'b0, poke: 1'b0};
      vecs[2] = '{hin: H_INIT, blk: ABC_BLK,   exp: ABC_DIG,   stall: 1'b1, poke: 1'b0};
      vecs[3] = '{hin: H_INIT, blk: ABC_BLK,   exp: ABC_DIG,   stall: 1'b0, poke: 1'b1};
      vecs[4] = '{hin: H_INIT, blk: EMPTY_BLK, exp: EMPTY_DIG, stall: 1'b1, poke: 1'b0};

      #12;
      chk("rst_w_ready", bus.w_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_round_idx", bus.round_idx, 0);
      chk("rst_digest", bus.digest_out, 0);
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         run_block(vecs[i].hin, vecs[i].blk, vecs[i].stall, vecs[i].poke, -1, dig, dc, ns);
         chk($sformatf("digest_vec%0d", i), dig, vecs[i].exp);
         chk($sformatf("done_cycle_vec%0d", i), dc, 65 + ns);
         @(negedge clock);
         bus.start = 1'b0;
         chk("done_one_cycle", bus.done, 0);
         chk("idle_after_final", bus.busy, 0);
         chk("digest_held", bus.digest_out, vecs[i].exp);
      end

      // Reset at round 30
      run_block(H_INIT, ABC_BLK, 1'b0, 1'b0, 30, dig, dc, ns);
      #2;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_digest", bus.digest_out, 0);
      chk("mid_rst_round_idx", bus.round_idx, 0);
      @(negedge clock); reset = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clock);
         if (bus.done || bus.busy) seen++;
      end
      chk("no_activity_after_rst", seen, 0);
      run_block(H_INIT, ABC_BLK, 1'b0, 1'b0, -1, dig, dc, ns);
      chk("abc_after_rst", dig, ABC_DIG);
      chk("abc_after_rst_cycle", dc, 65);

      // Two-block message, second start in the first IDLE cycle
      expand(B1_BLK);
      mid = model_compress(H_INIT);
      run_block(H_INIT, B1_BLK, 1'b0, 1'b0, -1, dig, dc, ns);
      chk("two_block_first", dig, mid);
      run_block(mid, B2_BLK, 1'b0, 1'b0, -1, dig, dc, ns);
      chk("two_block_final", dig, TWO_DIG);
      chk("two_block_cycle", dc, 65);
      @(negedge clock);
      chk("two_block_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
